// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR request sequencer:
//   - state_e          : sequencer FSM states
//   - CSRRW..CSRRCI    : funct3 encodings of the Zicsr instructions
//   - CSR_OP_R/CSR_OP_W: bit positions inside the 2-bit bus op
//   - CSR_ADDR_RO      : csr_addr[11:10] value marking a read-only CSR
// -----------------------------------------------------------------------------
package csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam int CSR_OP_R = 1;
    localparam int CSR_OP_W = 0;

    localparam logic [1:0] CSR_ADDR_RO = 2'b11;

endpackage

// File: rtl/csr_op_decode.sv
// -----------------------------------------------------------------------------
// csr_op_decode
// Combinational decode of a CSR instruction into the bus R/W op.
// Ports:
//   funct3_lo_i  in  2  funct3[1:0] (bit 2 only selects reg/imm source)
//   rd_idx_i     in  5  destination register
//   rs1_idx_i    in  5  rs1 index / uimm
//   addr_hi_i    in  2  csr_addr[11:10] (access-permission field)
//   op_o         out 2  [CSR_OP_R]=read, [CSR_OP_W]=write
//   illegal_o    out 1  illegal-instruction
// -----------------------------------------------------------------------------
module csr_op_decode
    import csr_pkg::*;
(
    input  logic [1:0] funct3_lo_i,
    input  logic [4:0] rd_idx_i,
    input  logic [4:0] rs1_idx_i,
    input  logic [1:0] addr_hi_i,
    output logic [1:0] op_o,
    output logic       illegal_o
);

    always_comb begin
        op_o = 2'b00;
        case (funct3_lo_i)
            CSRRW[1:0]: begin
                // CSRRW with rd=x0 must not read (no side effects of a read)
                op_o[CSR_OP_W] = 1'b1;
                op_o[CSR_OP_R] = (rd_idx_i != 5'd0);
            end
            CSRRS[1:0], CSRRC[1:0]: begin
                // set/clear with rs1/uimm=0 is a pure read
                op_o[CSR_OP_R] = 1'b1;
                op_o[CSR_OP_W] = (rs1_idx_i != 5'd0);
            end
            default: op_o = 2'b00;
        endcase
        illegal_o = (funct3_lo_i == 2'b00) ||
                    (op_o[CSR_OP_W] && (addr_hi_i == CSR_ADDR_RO));
    end

endmodule

// File: rtl/csr_req_ctrl.sv
// -----------------------------------------------------------------------------
// csr_req_ctrl
// Upstream request sequencer for the CSR bus. Takes one CSR instruction at a
// time from the core, decodes it into a bus R/W op, presents the access to the
// CSR bus (held stable until the addressed unit answers) and returns the old
// CSR value / exception to writeback.
//
// Optional feature: define CSR_REQ_TIMEOUT_EN to abort an access that gets no
// csr_rvalid within TIMEOUT_CYC cycles of ISSUE+WAIT (raises rsp_exc). Without
// it the sequencer waits indefinitely for csr_rvalid or rst.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         core request handshake
//   req_funct3, req_csr_addr,
//   req_rs1_idx, req_rs1_val,
//   req_rd_idx                  instruction fields captured at accept
//   rsp_valid/rsp_ready         writeback handshake
//   rsp_rdata, rsp_rd_idx,
//   rsp_rd_wen, rsp_exc         writeback payload
//   csr_op, csr_funct3, csr_imm,
//   rs1_val, csr_addr           bus access fields (zero outside ISSUE/WAIT)
//   csr_valid                   one-cycle access strobe (ISSUE)
//   csr_rrsp                    ack of csr_rvalid
//   csr_rdata, csr_rvalid,
//   csr_reg_rsp                 bus response (reg_rsp=1 -> exception)
// -----------------------------------------------------------------------------
module csr_req_ctrl
    import csr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int REG_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_csr_addr,
    input  logic [4:0]            req_rs1_idx,
    input  logic [REG_WIDTH-1:0]  req_rs1_val,
    input  logic [4:0]            req_rd_idx,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic [4:0]            rsp_rd_idx,
    output logic                  rsp_rd_wen,
    output logic                  rsp_exc,
    output logic [1:0]            csr_op,
    output logic [2:0]            csr_funct3,
    output logic [4:0]            csr_imm,
    output logic [REG_WIDTH-1:0]  rs1_val,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic                  csr_valid,
    output logic                  csr_rrsp,
    input  logic [ADDR_WIDTH-1:0] csr_rdata,
    input  logic                  csr_rvalid,
    input  logic                  csr_reg_rsp
);

    state_e                state_q, state_d;
    logic [1:0]            op_q;
    logic [2:0]            funct3_q;
    logic [4:0]            imm_q;
    logic [4:0]            rd_q;
    logic [REG_WIDTH-1:0]  rs1_val_q;
    logic [REG_WIDTH-1:0]  rdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  exc_q;

    logic [1:0] dec_op;
    logic       dec_illegal;
    logic       accept;
    logic       bus_active;
    logic       rvalid_seen;
    logic       timeout;

    csr_op_decode u_decode (
        .funct3_lo_i (req_funct3[1:0]),
        .rd_idx_i    (req_rd_idx),
        .rs1_idx_i   (req_rs1_idx),
        .addr_hi_i   (req_csr_addr[11:10]),
        .op_o        (dec_op),
        .illegal_o   (dec_illegal)
    );

    assign accept      = (state_q == ST_IDLE) && req_valid;
    assign bus_active  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign rvalid_seen = bus_active && csr_rvalid;

`ifdef CSR_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero while idle, so it starts from zero on ISSUE entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (bus_active) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last of TIMEOUT_CYC bus cycles without an answer.
    assign timeout = bus_active && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = dec_illegal ? ST_RESP : ST_ISSUE;
            ST_ISSUE,
            ST_WAIT:  begin
                if (csr_rvalid || timeout) state_d = ST_RESP;
                else                       state_d = ST_WAIT;
            end
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Payload registers: only observable through state-gated outputs, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= dec_op;
            funct3_q  <= req_funct3;
            imm_q     <= req_rs1_idx;
            rd_q      <= req_rd_idx;
            rs1_val_q <= req_rs1_val;
            addr_q    <= req_csr_addr;
            exc_q     <= dec_illegal;
            rdata_q   <= '0;
        end else if (rvalid_seen) begin
            exc_q     <= csr_reg_rsp;
            rdata_q   <= csr_reg_rsp ? '0 : REG_WIDTH'(csr_rdata);
        end else if (timeout) begin
            exc_q     <= 1'b1;
            rdata_q   <= '0;
        end
    end

    // Output logic
    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_rd_idx = '0;
        rsp_rd_wen = 1'b0;
        rsp_exc    = 1'b0;
        csr_op     = '0;
        csr_funct3 = '0;
        csr_imm    = '0;
        rs1_val    = '0;
        csr_addr   = '0;
        csr_valid  = 1'b0;
        // Reset abandons the access, so it is not acknowledged either.
        csr_rrsp   = rvalid_seen && !rst;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_ISSUE,
            ST_WAIT: begin
                csr_valid  = (state_q == ST_ISSUE);
                csr_op     = op_q;
                csr_funct3 = funct3_q;
                csr_imm    = imm_q;
                rs1_val    = rs1_val_q;
                csr_addr   = addr_q;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = rdata_q;
                rsp_rd_idx = rd_q;
                rsp_exc    = exc_q;
                rsp_rd_wen = op_q[CSR_OP_R] && !exc_q && (rd_q != 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_req_ctrl.sv
module tb_csr_req_ctrl;

    localparam int AW      = 32;
    localparam int RW      = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [RW-1:0] rdata;
        logic [4:0]    rd_idx;
        logic          rd_wen;
        logic          exc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_csr_addr;
    logic [4:0]    req_rs1_idx;
    logic [RW-1:0] req_rs1_val;
    logic [4:0]    req_rd_idx;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_rdata;
    logic [4:0]    rsp_rd_idx;
    logic          rsp_rd_wen;
    logic          rsp_exc;
    logic [1:0]    csr_op;
    logic [2:0]    csr_funct3;
    logic [4:0]    csr_imm;
    logic [RW-1:0] rs1_val;
    logic [AW-1:0] csr_addr;
    logic          csr_valid;
    logic          csr_rrsp;
    logic [AW-1:0] csr_rdata;
    logic          csr_rvalid;
    logic          csr_reg_rsp;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    csr_req_ctrl #(
        .ADDR_WIDTH  (AW),
        .REG_WIDTH   (RW),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_csr_addr (req_csr_addr),
        .req_rs1_idx  (req_rs1_idx),
        .req_rs1_val  (req_rs1_val),
        .req_rd_idx   (req_rd_idx),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_rd_idx   (rsp_rd_idx),
        .rsp_rd_wen   (rsp_rd_wen),
        .rsp_exc      (rsp_exc),
        .csr_op       (csr_op),
        .csr_funct3   (csr_funct3),
        .csr_imm      (csr_imm),
        .rs1_val      (rs1_val),
        .csr_addr     (csr_addr),
        .csr_valid    (csr_valid),
        .csr_rrsp     (csr_rrsp),
        .csr_rdata    (csr_rdata),
        .csr_rvalid   (csr_rvalid),
        .csr_reg_rsp  (csr_reg_rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".req_ready"}, req_ready, 1);
        check({tag, ".rsp_valid"}, rsp_valid, 0);
        check({tag, ".csr_valid"}, csr_valid, 0);
        check({tag, ".csr_rrsp"},  csr_rrsp, 0);
        check({tag, ".bus"},       {csr_op, csr_funct3, csr_imm, rs1_val, csr_addr}, 0);
        check({tag, ".rsp"},       {rsp_rdata, rsp_rd_idx, rsp_rd_wen, rsp_exc}, 0);
    endtask

    // Drives one request and follows it to its writeback handshake.
    // bdly: cycle (0 = ISSUE cycle) in which the bus answers; <0 never answers.
    // rwait: cycles rsp_ready is held low once rsp_valid appears.
    task automatic run_req(input string name, input logic [2:0] f3, input logic [AW-1:0] addr,
                           input logic [4:0] rs1i, input logic [RW-1:0] rs1v, input logic [4:0] rd,
                           input int bdly, input logic [AW-1:0] brd, input logic bexc,
                           input int rwait);
        logic r, w, ill;
        exp_t e;
        int   c, lat;
        bit   got;

        // reference decode
        r = 1'b0; w = 1'b0;
        if (f3[1:0] == 2'b01) begin
            w = 1'b1; r = (rd != 0);
        end else if (f3[1:0] != 2'b00) begin
            r = 1'b1; w = (rs1i != 0);
        end
        ill = (f3[1:0] == 2'b00) || (w && addr[11:10] == 2'b11);
        e.rd_idx = rd;
        if (ill || bdly < 0 || bexc) begin
            e.exc = 1'b1; e.rdata = '0; e.rd_wen = 1'b0;
        end else begin
            e.exc = 1'b0; e.rdata = brd; e.rd_wen = r && (rd != 0);
        end
        lat = ill ? 0 : (bdly >= 0 ? bdly + 1 : TIMEOUT);
        sb.push_back(e);

        check({name, ".req_ready_idle"}, req_ready, 1);
        req_valid = 1'b1; req_funct3 = f3; req_csr_addr = addr;
        req_rs1_idx = rs1i; req_rs1_val = rs1v; req_rd_idx = rd;
        tick();
        // scramble request fields: bus must present the captured copy
        req_valid = 1'b0; req_funct3 = ~f3; req_csr_addr = ~addr;
        req_rs1_idx = ~rs1i; req_rs1_val = ~rs1v; req_rd_idx = ~rd;

        c = 0; got = 0;
        while (!got && c < 64) begin
            csr_rvalid  = !ill && (bdly >= 0) && (c == bdly);
            csr_rdata   = brd;
            csr_reg_rsp = bexc;
            #1;
            if (rsp_valid) begin
                got = 1;
                check({name, ".latency"}, c, lat);
                for (int h = 0; h <= rwait; h++) begin
                    if (h > 0) tick();
                    csr_rvalid = (h % 2 == 1);
                    rsp_ready  = (h == rwait);
                    #1;
                    check({name, ".rsp_valid"}, rsp_valid, 1);
                    check({name, ".rsp_rdata"}, rsp_rdata, sb[0].rdata);
                    check({name, ".rsp_rd_idx"}, rsp_rd_idx, sb[0].rd_idx);
                    check({name, ".rsp_rd_wen"}, rsp_rd_wen, sb[0].rd_wen);
                    check({name, ".rsp_exc"}, rsp_exc, sb[0].exc);
                    check({name, ".resp_req_ready"}, req_ready, 0);
                    check({name, ".resp_no_rrsp"}, csr_rrsp, 0);
                    check({name, ".resp_bus_zero"}, {csr_valid, csr_op, csr_addr}, 0);
                end
                void'(sb.pop_front());
                tick();
                rsp_ready = 1'b0; csr_rvalid = 1'b0;
                #1;
                check({name, ".back_idle"}, req_ready, 1);
                check({name, ".rsp_dropped"}, rsp_valid, 0);
            end else begin
                check({name, ".busy_req_ready"}, req_ready, 0);
                check({name, ".csr_valid"}, csr_valid, (c == 0) && !ill);
                if (!ill) begin
                    check({name, ".csr_addr"}, csr_addr, addr);
                    check({name, ".csr_rrsp"}, csr_rrsp, csr_rvalid);
                end
                if (c == 0 && !ill) begin
                    check({name, ".csr_op"}, csr_op, {r, w});
                    check({name, ".csr_funct3"}, csr_funct3, f3);
                    check({name, ".csr_imm"}, csr_imm, rs1i);
                    check({name, ".rs1_val"}, rs1_val, rs1v);
                end
                tick();
                c++;
            end
        end
        check({name, ".rsp_seen"}, got, 1);
        if (!got) sb.delete();
        csr_rvalid = 1'b0;
    endtask

    // Starts a legal access that never gets an answer, waits `wcyc` bus
    // cycles, then resets with a stray rvalid around the reset edge.
    task automatic reset_in_wait(input string name, input int wcyc);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 32'h7C0;
        req_rs1_idx = 5'd2; req_rs1_val = 32'h1234_5678; req_rd_idx = 5'd1;
        tick();
        req_valid = 1'b0;
        repeat (wcyc) tick();
        check({name, ".wait_req_ready"}, req_ready, 0);
        check({name, ".wait_no_rsp"}, rsp_valid, 0);
        check({name, ".wait_addr"}, csr_addr, 32'h7C0);
        check({name, ".wait_no_strobe"}, csr_valid, 0);
        rst = 1'b1; csr_rvalid = 1'b1; csr_rdata = 32'hAAAA_5555; csr_reg_rsp = 1'b0;
        #1;
        check({name, ".rst_no_rrsp"}, csr_rrsp, 0);
        tick();
        rst = 1'b0;
        #1;
        check_idle_outputs({name, ".after_rst"});
        tick();
        csr_rvalid = 1'b0;
        #1;
        check_idle_outputs({name, ".stray_ignored"});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0;
        req_rs1_idx = '0; req_rs1_val = '0; req_rd_idx = '0; rsp_ready = 1'b0;
        csr_rdata = '0; csr_rvalid = 1'b0; csr_reg_rsp = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        run_req("rs_read",   3'b010, 32'h3A0, 5'd0, 32'h0,         5'd5, 3, 32'h1F1F,      1'b0, 0);
        run_req("rw_nord",   3'b001, 32'h3B0, 5'd7, 32'h8000_0000, 5'd0, 0, 32'h55,        1'b0, 0);
        run_req("f3_100",    3'b100, 32'h300, 5'd1, 32'h0,         5'd3, 0, 32'h0,         1'b0, 0);
        run_req("rw_ro",     3'b001, 32'hC00, 5'd1, 32'hFFFF,      5'd3, 0, 32'h0,         1'b0, 1);
        run_req("rs_ro_rd",  3'b010, 32'hC00, 5'd0, 32'h0,         5'd4, 1, 32'hCAFE,      1'b0, 0);
        run_req("bus_exc",   3'b011, 32'h300, 5'd3, 32'hF0,        5'd6, 2, 32'h9999,      1'b1, 5);
        run_req("rsi_hold",  3'b110, 32'h340, 5'd9, 32'h0,         5'd7, 0, 32'hDEAD_BEEF, 1'b0, 2);
        run_req("rci_ro",    3'b111, 32'hC01, 5'd4, 32'h0,         5'd8, 0, 32'h0,         1'b0, 0);

`ifdef CSR_REQ_TIMEOUT_EN
        run_req("timeout",   3'b010, 32'h7C0, 5'd0, 32'h0,         5'd9, -1, 32'h0,        1'b0, 0);
        reset_in_wait("rst_wait", 3);
`else
        reset_in_wait("no_timeout", 100);
        reset_in_wait("rst_wait", 3);
`endif
        run_req("fresh",     3'b001, 32'h305, 5'd1, 32'h8000_0100, 5'd10, 1, 32'h0000_0100, 1'b0, 0);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
